// File: rtl/result_display_mux.sv
// N-digit multiplexed 7-segment result display with reset synchroniser,
// heartbeat divider, result history (newest on digit 0) and saturating counter.
module result_display_mux #(
   parameter int NUM_DIGITS     = 4,
   parameter int RESULT_W       = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int SCAN_DIV       = 50000,
   parameter int HB_DIV         = 25000000,
   parameter bit HEX_EN         = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n_pin,
   input  logic                  result_valid,
   input  logic [RESULT_W-1:0]   result_in,
   input  logic                  clear,
   output logic                  rst_n,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  heartbeat,
   output logic [15:0]           result_count
);

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [HB_W-1:0]       HB_LAST   = HB_W'(HB_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   logic [NUM_DIGITS-1:0]               hist_valid_q, hist_valid_d;
   logic [NUM_DIGITS-1:0][RESULT_W-1:0] hist_code_q, hist_code_d;
   logic [15:0]                         count_q, count_d;
   logic [SCAN_W-1:0]                   scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]                    scan_idx_q, scan_idx_d;
   logic [HB_W-1:0]                     hb_cnt_q, hb_cnt_d;
   logic                                hb_q, hb_d;
   logic [6:0]                          seg_q, seg_d;
   logic [NUM_DIGITS-1:0]               an_q, an_d;

   logic                  sel_valid;
   logic [RESULT_W-1:0]   sel_code;
   logic [NUM_DIGITS-1:0] onehot;

   // Active-low pattern table; out-of-range or invalid entries are blank.
   function automatic logic [6:0] decode(input logic valid, input logic [3:0] code);
      logic [6:0] pat;
      pat = 7'h7F;
      if (valid) begin
         case (code)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = HEX_EN ? 7'h08 : 7'h7F;
            4'hB: pat = HEX_EN ? 7'h03 : 7'h7F;
            4'hC: pat = HEX_EN ? 7'h46 : 7'h7F;
            4'hD: pat = HEX_EN ? 7'h21 : 7'h7F;
            4'hE: pat = HEX_EN ? 7'h06 : 7'h7F;
            default: pat = HEX_EN ? 7'h0E : 7'h7F;
         endcase
      end
      return SEG_ACTIVE_LOW ? pat : ~pat;
   endfunction

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n_pin) begin
      if (!rst_n_pin) sync_q <= '0;
      else            sync_q <= sync_d;
   end

   assign rst_n = sync_q[SYNC_STAGES-1];

   // Clear takes priority over a simultaneous strobe.
   always_comb begin
      hist_valid_d = hist_valid_q;
      hist_code_d  = hist_code_q;
      count_d      = count_q;
      if (clear) begin
         hist_valid_d = '0;
         count_d      = '0;
      end else if (result_valid) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hist_valid_d[i] = hist_valid_q[i-1];
            hist_code_d[i]  = hist_code_q[i-1];
         end
         hist_valid_d[0] = 1'b1;
         hist_code_d[0]  = result_in;
         if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
      end

      hb_cnt_d = hb_cnt_q + HB_W'(1);
      hb_d     = hb_q;
      if (hb_cnt_q == HB_LAST) begin
         hb_cnt_d = '0;
         hb_d     = ~hb_q;
      end
   end

   // seg and an come from the same scan index so they switch together.
   always_comb begin
      sel_valid = 1'b0;
      sel_code  = '0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx_q == IDX_W'(i)) begin
            onehot[i] = 1'b1;
            sel_valid = hist_valid_q[i];
            sel_code  = hist_code_q[i];
         end
      end
      seg_d = decode(sel_valid, 4'(sel_code));
      an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_valid_q <= '0;
         hist_code_q  <= '0;
         count_q      <= '0;
         scan_cnt_q   <= '0;
         scan_idx_q   <= '0;
         hb_cnt_q     <= '0;
         hb_q         <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_code_q  <= hist_code_d;
         count_q      <= count_d;
         scan_cnt_q   <= scan_cnt_d;
         scan_idx_q   <= scan_idx_d;
         hb_cnt_q     <= hb_cnt_d;
         hb_q         <= hb_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg          = seg_q;
   assign an           = an_q;
   assign heartbeat    = hb_q;
   assign result_count = count_q;

endmodule

// File: tb/tb_result_display_mux.sv
// Randomised self-checking bench: a 4-digit decimal display and a 1-digit hex
// display share one stimulus stream and are compared against a queue-based model.
module tb_result_display_mux;

   localparam int SCAN = 4;
   localparam int HB   = 8;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n_pin = 1'b1;
   logic       result_valid = 1'b0;
   logic [3:0] result_in = 4'h0;
   logic       clear = 1'b0;

   logic       rst_n_a, rst_n_b, hb_a, hb_b;
   logic [6:0] seg_a, seg_b;
   logic [3:0] an_a;
   logic [0:0] an_b;
   logic [15:0] count_a, count_b;

   result_display_mux #(.NUM_DIGITS(4), .RESULT_W(4), .SYNC_STAGES(SYNC), .SCAN_DIV(SCAN),
                        .HB_DIV(HB), .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
   dut_a (.clk(clk), .rst_n_pin(rst_n_pin), .result_valid(result_valid), .result_in(result_in),
          .clear(clear), .rst_n(rst_n_a), .seg(seg_a), .an(an_a), .heartbeat(hb_a),
          .result_count(count_a));

   result_display_mux #(.NUM_DIGITS(1), .RESULT_W(4), .SYNC_STAGES(SYNC), .SCAN_DIV(SCAN),
                        .HB_DIV(HB), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
   dut_b (.clk(clk), .rst_n_pin(rst_n_pin), .result_valid(result_valid), .result_in(result_in),
          .clear(clear), .rst_n(rst_n_b), .seg(seg_b), .an(an_b), .heartbeat(hb_b),
          .result_count(count_b));

   always #5 clk = ~clk;

   int num_compared = 0;
   int num_mismatched = 0;

   logic [6:0] pat_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int hist_a[$];
   int hist_b[$];
   int model_count = 0;
   int edges = 0;
   logic [6:0] exp_seg_a, exp_seg_b;
   logic [3:0] exp_an_a;
   logic       exp_an_b, exp_hb;

   function automatic logic [6:0] expSeg(input bit valid, input int code, input bit hex);
      if (!valid || (code >= 10 && !hex)) return 7'h7F;
      return pat_tbl[code];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_compared++;
      if (observed !== expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic setResetExp();
      exp_seg_a = 7'h7F;
      exp_seg_b = 7'h7F;
      exp_an_a  = 4'hF;
      exp_an_b  = 1'b1;
      exp_hb    = 1'b0;
      hist_a.delete();
      hist_b.delete();
      model_count = 0;
   endtask

   // Drives one cycle of inputs, advances the model across the edge, then releases strobes.
   task automatic applyStimulus(input bit v, input int code, input bit clr);
      int k, d, c;
      result_valid = v;
      result_in    = 4'(code);
      clear        = clr;
      @(posedge clk);
      if (rst_n_pin) edges++;
      k = edges - SYNC;
      if (k < 1) begin
         setResetExp();
      end else begin
         d = ((k - 1) / SCAN) % 4;
         c = (d < hist_a.size()) ? hist_a[d] : 0;
         exp_seg_a = expSeg(d < hist_a.size(), c, 1'b0);
         exp_an_a  = ~(4'b0001 << d);
         c = (hist_b.size() > 0) ? hist_b[0] : 0;
         exp_seg_b = expSeg(hist_b.size() > 0, c, 1'b1);
         exp_an_b  = 1'b0;
         exp_hb    = ((k / HB) % 2) == 1;
         if (clr) begin
            hist_a.delete();
            hist_b.delete();
            model_count = 0;
         end else if (v) begin
            hist_a.push_front(code);
            if (hist_a.size() > 4) void'(hist_a.pop_back());
            hist_b.push_front(code);
            if (hist_b.size() > 1) void'(hist_b.pop_back());
            if (model_count < 65535) model_count++;
         end
      end
      #1;
      result_valid = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic checkAll();
      logic exp_rst;
      exp_rst = (edges >= SYNC);
      checkOutput("rst_n_a", 32'(rst_n_a), 32'(exp_rst));
      checkOutput("rst_n_b", 32'(rst_n_b), 32'(exp_rst));
      checkOutput("seg_a",   32'(seg_a),   32'(exp_seg_a));
      checkOutput("an_a",    32'(an_a),    32'(exp_an_a));
      checkOutput("seg_b",   32'(seg_b),   32'(exp_seg_b));
      checkOutput("an_b",    32'(an_b),    32'(exp_an_b));
      checkOutput("hb_a",    32'(hb_a),    32'(exp_hb));
      checkOutput("count_a", 32'(count_a), 32'(model_count));
      checkOutput("count_b", 32'(count_b), 32'(model_count));
   endtask

   initial begin
      int hist_codes[5] = '{3, 7, 1, 9, 5};

      #1 rst_n_pin = 1'b0;
      setResetExp();
      applyStimulus(0, 0, 0);
      applyStimulus(1, 4, 0);
      checkAll();

      $display("[TB] reset release");
      rst_n_pin = 1'b1;
      applyStimulus(0, 0, 0);
      checkAll();
      applyStimulus(0, 0, 0);
      checkAll();

      $display("[TB] idle scan");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 0, 0);
         checkAll();
      end

      $display("[TB] history 3,7,1,9,5");
      foreach (hist_codes[i]) begin
         applyStimulus(1, hist_codes[i], 0);
         checkAll();
      end
      checkOutput("hist_count", 32'(count_a), 32'd5);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 0, 0);
         checkAll();
      end

      $display("[TB] hex and blank");
      applyStimulus(1, 11, 0);
      checkAll();
      applyStimulus(0, 0, 0);
      checkAll();
      checkOutput("hex_b", 32'(seg_b), 32'h03);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0);
         checkAll();
      end

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                       $urandom_range(0, 19) == 0);
         checkAll();
      end

      $display("[TB] clear collision");
      applyStimulus(1, 2, 1);
      checkAll();
      checkOutput("clear_count", 32'(count_a), 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0);
         checkAll();
         checkOutput("clear_blank", 32'(seg_a), 32'h7F);
      end

      $display("[TB] saturation");
      for (int i = 0; i < 65534; i++) applyStimulus(1, int'($urandom_range(0, 15)), 0);
      checkAll();
      checkOutput("sat_fffe", 32'(count_a), 32'h0000FFFE);
      applyStimulus(1, 6, 0);
      checkAll();
      checkOutput("sat_ffff_1", 32'(count_a), 32'h0000FFFF);
      applyStimulus(1, 8, 0);
      checkAll();
      checkOutput("sat_ffff_2", 32'(count_a), 32'h0000FFFF);

      $display("[TB] reset mid-run");
      for (int i = 0; i < 6; i++) applyStimulus(1, int'($urandom_range(0, 9)), 0);
      #2 rst_n_pin = 1'b0;
      #1;
      edges = 0;
      setResetExp();
      checkAll();
      applyStimulus(1, 5, 0);
      checkAll();
      rst_n_pin = 1'b1;
      applyStimulus(0, 0, 0);
      checkAll();
      applyStimulus(0, 0, 0);
      checkAll();
      for (int i = 0; i < 24; i++) begin
         applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), 1'b0);
         checkAll();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
